// File: rtl/qmem_arb2_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmem_arb2_pkg : shared constants and types for the two-master qmem arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
package qmem_arb2_pkg;

  localparam int PRIO_RR     = 0;
  localparam int PRIO_FIXED  = 1;
  localparam int TMO_CNT_DEF = 50_000;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_LOCK = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/qmem_arb2_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmem_arb2_if : one qmem bus (request, write data, read data, ack/err)
// Rev 1.0
// ---------------------------------------------------------------------------
interface qmem_arb2_if
  import qmem_arb2_pkg::*;
#(
  parameter int QAW = 22,
  parameter int QDW = 32,
  parameter int QSW = QDW / 8
);

  logic [QAW-1:0] adr;
  logic           cs;
  logic           we;
  logic [QSW-1:0] sel;
  logic [QDW-1:0] dat_w;
  logic [QDW-1:0] dat_r;
  logic           ack;
  logic           err;

  modport master (output adr, cs, we, sel, dat_w, input dat_r, ack, err);
  modport slave  (input adr, cs, we, sel, dat_w, output dat_r, ack, err);

endinterface
`default_nettype wire

// File: rtl/qmem_arb_tmo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmem_arb_tmo : stall counter, expired on the last permitted stall cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module qmem_arb_tmo
  import qmem_arb2_pkg::*;
#(
  parameter int          TMO_W   = 16,
  parameter int unsigned TMO_CNT = TMO_CNT_DEF
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic i_clr,
  input  wire logic i_inc,
  output logic      o_expired
);

  localparam logic [TMO_W-1:0] LAST_CNT = TMO_W'(TMO_CNT - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/qmem_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// qmem_arb2 : zero-latency two-master arbiter for one qmem slave, with
//             grant lock across stalls and hung-slave timeout. Rev 1.0
// ---------------------------------------------------------------------------
module qmem_arb2
  import qmem_arb2_pkg::*;
#(
  parameter int          QAW       = 22,
  parameter int          QDW       = 32,
  parameter int          QSW       = QDW / 8,
  parameter int          PRIO_MODE = PRIO_RR,
  parameter int          TMO_W     = 16,
  parameter int unsigned TMO_CNT   = TMO_CNT_DEF
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  qmem_arb2_if.slave      m0,
  qmem_arb2_if.slave      m1,
  qmem_arb2_if.master     s,
  output logic [1:0]      gnt
);

  arb_state_t     r_state;
  arb_state_t     w_state_nxt;
  logic           r_owner;
  logic           w_owner_nxt;
  logic           r_last;
  logic           w_last_nxt;

  logic           w_pick_vld;
  logic           w_pick;
  logic           w_s_cs;
  logic [QAW-1:0] w_adr;
  logic           w_we;
  logic [QSW-1:0] w_sel;
  logic [QDW-1:0] w_dat_w;
  logic           w_expired;
  logic           w_timeout;
  logic           w_err;
  logic           w_done;
  logic           w_stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_owner <= 1'b0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
    end
  end

  // Owner dropping cs while locked just releases the lock; last is untouched.
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    if (w_s_cs) begin
      if (w_done) begin
        w_state_nxt = ST_IDLE;
        w_last_nxt  = w_pick;
      end else begin
        w_state_nxt = ST_LOCK;
        w_owner_nxt = w_pick;
      end
    end else if (r_state == ST_LOCK) begin
      w_state_nxt = ST_IDLE;
    end
  end

  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = 1'b0;
    if (r_state == ST_LOCK) begin
      w_pick_vld = 1'b1;
      w_pick     = r_owner;
    end else if (m0.cs && m1.cs) begin
      w_pick_vld = 1'b1;
      w_pick     = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~r_last;
    end else if (m0.cs || m1.cs) begin
      w_pick_vld = 1'b1;
      w_pick     = m1.cs;
    end
    w_s_cs    = w_pick_vld & (w_pick ? m1.cs : m0.cs);
    w_adr     = w_pick ? m1.adr   : m0.adr;
    w_we      = w_pick ? m1.we    : m0.we;
    w_sel     = w_pick ? m1.sel   : m0.sel;
    w_dat_w   = w_pick ? m1.dat_w : m0.dat_w;
    w_timeout = (r_state == ST_LOCK) & w_s_cs & w_expired & ~s.ack;
    w_err     = s.err | w_timeout;
    w_done    = s.ack | w_err;
    w_stall   = w_s_cs & ~w_done;
    gnt       = w_s_cs ? (w_pick ? 2'b10 : 2'b01) : 2'b00;
  end

  qmem_arb_tmo #(
    .TMO_W   (TMO_W),
    .TMO_CNT (TMO_CNT)
  ) u_tmo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clr     (~w_stall),
    .i_inc     (w_stall),
    .o_expired (w_expired)
  );

  assign s.cs    = w_s_cs;
  assign s.adr   = w_adr;
  assign s.we    = w_we;
  assign s.sel   = w_sel;
  assign s.dat_w = w_dat_w;

  assign m0.ack   = w_s_cs & ~w_pick & s.ack;
  assign m0.err   = w_s_cs & ~w_pick & w_err;
  assign m1.ack   = w_s_cs &  w_pick & s.ack;
  assign m1.err   = w_s_cs &  w_pick & w_err;
  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;

endmodule
`default_nettype wire

// File: tb/tb_qmem_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_qmem_arb2 : directed checks of round-robin and fixed-priority arbiters
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_qmem_arb2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] gnt_a;
  logic [1:0] gnt_b;
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  qmem_arb2_if #(.QAW(22), .QDW(32)) ma0 ();
  qmem_arb2_if #(.QAW(22), .QDW(32)) ma1 ();
  qmem_arb2_if #(.QAW(22), .QDW(32)) sa  ();
  qmem_arb2_if #(.QAW(22), .QDW(32)) mb0 ();
  qmem_arb2_if #(.QAW(22), .QDW(32)) mb1 ();
  qmem_arb2_if #(.QAW(22), .QDW(32)) sb  ();

  qmem_arb2 #(.PRIO_MODE(0), .TMO_CNT(8)) u_rr (
    .clk (clk), .rst_n (rst_n), .m0 (ma0), .m1 (ma1), .s (sa), .gnt (gnt_a)
  );

  qmem_arb2 #(.PRIO_MODE(1), .TMO_CNT(8)) u_fx (
    .clk (clk), .rst_n (rst_n), .m0 (mb0), .m1 (mb1), .s (sb), .gnt (gnt_b)
  );

  // The fixed-priority instance sees the same stimulus as the round-robin one.
  assign mb0.adr   = ma0.adr;
  assign mb0.cs    = ma0.cs;
  assign mb0.we    = ma0.we;
  assign mb0.sel   = ma0.sel;
  assign mb0.dat_w = ma0.dat_w;
  assign mb1.adr   = ma1.adr;
  assign mb1.cs    = ma1.cs;
  assign mb1.we    = ma1.we;
  assign mb1.sel   = ma1.sel;
  assign mb1.dat_w = ma1.dat_w;
  assign sb.dat_r  = sa.dat_r;
  assign sb.ack    = sa.ack;
  assign sb.err    = sa.err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ma0.cs = 1'b0; ma0.we = 1'b0; ma0.adr = '0; ma0.sel = 4'hF; ma0.dat_w = '0;
    ma1.cs = 1'b0; ma1.we = 1'b0; ma1.adr = '0; ma1.sel = 4'hF; ma1.dat_w = '0;
    sa.ack = 1'b0; sa.err = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    sa.dat_r = '0;
    idle();
    cyc();
    cyc();
    #1;
    chk("rst_gnt", gnt_a, 2'b00);
    chk("rst_scs", sa.cs, 1'b0);
    chk("rst_ack", {ma0.ack, ma1.ack, ma0.err, ma1.err}, 4'b0000);
    rst_n = 1'b1;

    // both masters read word 0x80000C back to back
    cyc();
    ma0.cs = 1'b1; ma0.adr = 22'h200003;
    ma1.cs = 1'b1; ma1.adr = 22'h200003;
    sa.ack = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) cyc();
      sa.dat_r = 32'hA000_0000 + k;
      #1;
      chk($sformatf("rr_gnt%0d", k), gnt_a, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk($sformatf("rr_ack%0d", k), (k % 2 == 0) ? {ma0.ack, ma1.ack} : {ma1.ack, ma0.ack}, 2'b10);
      chk($sformatf("fx_gnt%0d", k), gnt_b, 2'b01);
      chk($sformatf("fx_m1ack%0d", k), mb1.ack, 1'b0);
      if (k > 0) begin
        chk($sformatf("rd_bcast%0d", k), (k % 2 == 1) ? ma0.dat_r : ma1.dat_r,
            32'hA000_0000 + k);
      end
    end

    // single write of 0x12 to 0x800008 by m0
    cyc();
    idle();
    ma0.cs = 1'b1; ma0.we = 1'b1; ma0.adr = 22'h200002; ma0.dat_w = 32'h12;
    sa.ack = 1'b1;
    #1;
    chk("wr_scs", sa.cs, 1'b1);
    chk("wr_sadr", sa.adr, 22'h200002);
    chk("wr_swe", sa.we, 1'b1);
    chk("wr_sdat", sa.dat_w, 32'h12);
    chk("wr_m0ack", ma0.ack, 1'b1);
    chk("wr_m1ack", ma1.ack, 1'b0);
    chk("wr_gnt", gnt_a, 2'b01);

    // slave error routed only to the requester
    cyc();
    idle();
    ma1.cs = 1'b1; ma1.adr = 22'h200004; sa.err = 1'b1;
    #1;
    chk("serr_m1", ma1.err, 1'b1);
    chk("serr_m0", ma0.err, 1'b0);

    // m1 stalled 5 cycles, m0 arrives in cycle 2 and must wait
    cyc();
    idle();
    ma1.cs = 1'b1; ma1.adr = 22'h111111;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) cyc();
      if (c == 2) begin
        ma0.cs = 1'b1; ma0.adr = 22'h222222;
      end
      if (c == 6) sa.ack = 1'b1;
      #1;
      chk($sformatf("stl_adr%0d", c), sa.adr, 22'h111111);
      chk($sformatf("stl_gnt%0d", c), gnt_a, 2'b10);
      chk($sformatf("stl_m1ack%0d", c), ma1.ack, (c == 6));
      chk($sformatf("stl_m0ack%0d", c), ma0.ack, 1'b0);
    end
    cyc();
    ma1.cs = 1'b0;
    #1;
    chk("stl_next_gnt", gnt_a, 2'b01);
    chk("stl_next_adr", sa.adr, 22'h222222);
    chk("stl_next_ack", ma0.ack, 1'b1);

    // hung slave: m0 errored on stall cycle 8, pending m1 served next
    cyc();
    idle();
    ma0.cs = 1'b1; ma0.adr = 22'h200005;
    for (int c = 1; c <= 8; c++) begin
      if (c > 1) cyc();
      if (c == 2) begin
        ma1.cs = 1'b1; ma1.adr = 22'h200006;
      end
      #1;
      chk($sformatf("tmo_err%0d", c), ma0.err, (c == 8));
      chk($sformatf("tmo_m1err%0d", c), ma1.err, 1'b0);
      if (c == 8) begin
        chk("tmo_scs", sa.cs, 1'b1);
        chk("tmo_gnt", gnt_a, 2'b01);
      end
    end
    cyc();
    ma0.cs = 1'b0;
    sa.ack = 1'b1;
    #1;
    chk("tmo_next_gnt", gnt_a, 2'b10);
    chk("tmo_next_ack", ma1.ack, 1'b1);
    chk("tmo_next_err", ma0.err, 1'b0);

    // reset during a stall aborts m0's access silently
    cyc();
    idle();
    ma0.cs = 1'b1; ma0.adr = 22'h200007;
    #1;
    chk("rs_gnt1", gnt_a, 2'b01);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    chk("rs_noack", {ma0.ack, ma0.err}, 2'b00);
    cyc();
    rst_n  = 1'b1;
    ma0.cs = 1'b0;
    #1;
    chk("rs_gnt_idle", gnt_a, 2'b00);
    chk("rs_noack2", {ma0.ack, ma0.err}, 2'b00);
    ma1.cs = 1'b1; sa.ack = 1'b1;
    #1;
    chk("rs_m1_gnt", gnt_a, 2'b10);
    chk("rs_m1_ack", ma1.ack, 1'b1);
    cyc();
    ma1.cs = 1'b0; ma0.cs = 1'b1;
    #1;
    chk("rs_m0_gnt", gnt_a, 2'b01);
    chk("rs_m0_ack", ma0.ack, 1'b1);

    cyc();
    idle();
    cyc();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/qmem_arb2.md
Name: qmem_arb2

Overview:
- Two-master, one-slave qmem arbiter.
- Shares one qmem slave (the control-register block at 0x800000) between two requesters: m0 (main CPU) and m1 (secondary master, e.g. a boot/debug loader).
- Adds zero latency to the granted master and holds the grant across multi-cycle stalls (slave ack low while UART/SPI is busy).
- Terminates a hung slave access with err after a programmable timeout.

Parameters:
- QAW, 22, qmem address width.
- QDW, 32, qmem data width.
- QSW, QDW/8, qmem select width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (m0 wins).
- TMO_W, 16, timeout counter width.
- TMO_CNT, 16'd50_000, stall cycles before forced err (1 ms at 50 MHz).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- m0_adr / m1_adr  in  QAW  master address.
- m0_cs / m1_cs  in  1  master request.
- m0_we / m1_we  in  1  master write enable.
- m0_sel / m1_sel  in  QSW  master byte selects.
- m0_dat_w / m1_dat_w  in  QDW  master write data.
- m0_dat_r / m1_dat_r  out  QDW  read data (broadcast from slave).
- m0_ack / m1_ack  out  1  master acknowledge.
- m0_err / m1_err  out  1  master error.
- s_adr  out  QAW  slave address.
- s_cs  out  1  slave select.
- s_we  out  1  slave write enable.
- s_sel  out  QSW  slave byte selects.
- s_dat_w  out  QDW  slave write data.
- s_dat_r  in  QDW  slave read data.
- s_ack  in  1  slave acknowledge (combinational; may stay low for many cycles).
- s_err  in  1  slave error.
- gnt  out  2  one-hot current grant (debug/status).

Behaviour:
- Clock and reset: clk only; all state is reset synchronously when rst_n = 0 on a clk edge.
- State registers:
  - locked (1b): a transaction is stalled and the grant is held.
  - owner (1b): index of the master holding the lock.
  - last (1b): master served most recently.
  - tmo (TMO_W): stall counter.
- Reset values: locked = 0, owner = 0, last = 1 (so m0 wins the first tie), tmo = 0.
- Arbitration (combinational selection `pick`):
  - If locked: pick = owner.
  - Else if exactly one master has cs set: pick = that master.
  - Else if both have cs set: PRIO_MODE = 1 gives m0; PRIO_MODE = 0 gives the master that is not `last`.
  - Else: no pick.
- Forwarding:
  - The picked master's adr/we/sel/dat_w drive the slave the same cycle.
  - s_cs = picked master's cs.
  - With no pick: s_cs = 0, other slave outputs are don't-care (driven from m0).
  - gnt is one-hot for the pick when s_cs = 1, otherwise 2'b00.
- Ack and err routing:
  - The picked master gets s_ack and (s_err | timeout).
  - The non-picked master gets ack = 0 and err = 0.
  - Both outputs are combinational, same cycle.
- Read data:
  - The slave presents read data the cycle after ack.
  - s_dat_r is broadcast unmodified to m0_dat_r and m1_dat_r.
  - Each master samples the data only after its own ack.
- Stall (s_cs = 1, s_ack = 0, no timeout): next state is locked = 1, owner = pick, tmo = tmo + 1.
- Completion (s_cs = 1 and s_ack = 1 or err): next state is locked = 0, last = pick, tmo = 0.
- Timeout:
  - Fires when locked and tmo == TMO_CNT - 1 while s_ack = 0.
  - Asserts err to the owner for exactly that cycle; counts as completion.
  - s_cs stays asserted that cycle; the slave sees the master drop cs next cycle.
- Owner drops cs while locked (protocol violation): locked = 0, tmo = 0, last unchanged, no ack/err generated.
- Simultaneous events:
  - New request arriving from the other master during a lock is ignored until the completion cycle.
  - Arbitration is re-evaluated in the cycle after completion.
  - Back-to-back requests from both masters alternate in PRIO_MODE 0.
- Reset mid-transaction: lock and counter are cleared and the next cycle re-arbitrates; the in-flight master is neither acked nor errored.
- Width/arith: tmo saturates logic is unnecessary (it is cleared at TMO_CNT - 1); TMO_CNT must be ≥ 2.

Decomposition:
- Shared package: PRIO_RR = 0 / PRIO_FIXED = 1 constants and the default TMO_CNT.
- One natural sub-module, qmem_arb_tmo: the stall timeout counter with inputs clr and inc, output expired.

Test Plan:
- Single master: m0 writes 0x12 to 0x800008 with s_ack = 1 → s_cs = 1 and m0_ack = 1 same cycle; gnt = 01; m1_ack = 0.
- Contention, RR: both masters read 0x80000C continuously with s_ack = 1 → grants m0, m1, m0, m1; each m*_dat_r equals s_dat_r one cycle after that master's ack.
- Stall hold: m1 granted, s_ack low 5 cycles, m0 raises cs in cycle 2 → s_adr stays m1_adr all 6 cycles; m1_ack on cycle 6; m0 granted cycle 7.
- Fixed priority: PRIO_MODE = 1, both request continuously → m0 granted every cycle, m1 never acked.
- Timeout: TMO_CNT = 8, s_ack held 0 → m0_err = 1 exactly on the 8th stall cycle, lock released, m1 pending request granted next cycle.
- Reset mid-stall: rst_n = 0 for 1 cycle during a 3-cycle stall → gnt = 00 after reset; next m0 request granted with no ack for the aborted access.
